mem_responder: RTL and testbench

- Memory-side responder for the two-port memory scheduler.
- Accepts a single arbitrated request stream (address, direction, write data) over a req/ack handshake.
- Executes each request against an external asynchronous 16-bit SRAM with programmable wait states.
- Returns read data with an ack pulse; out-of-range addresses are answered immediately with an error flag.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_wait_counter.sv | 40 ++++
 rtl/mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-side responder and related timing blocks:
// FSM state encoding, default address width, data width, the value returned
// for out-of-range reads and the wait-counter width.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned DEF_ADDR_W = 18;
  localparam int unsigned MEMDAT_W   = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [MEMDAT_W-1:0] OOR_READ_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } mem_state_e;

  // True when any address bit at or above addr_w is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned addr_w);
    return ((addr >> addr_w) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter used to time SRAM access phases.
// Ports:
//   clk        - system clock (rising edge)
//   rst        - synchronous active-low reset
//   i_load     - load i_load_val (takes priority over i_dec)
//   i_load_val - value to load
//   i_dec      - decrement by one; holds at zero
//   o_done     - count is zero
// -----------------------------------------------------------------------------
module mem_wait_counter
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_load_val,
  input  logic                  i_dec,
  output logic                  o_done
);

  logic [WAIT_CNT_W-1:0] r_count;

  // Count register: load, then decrement towards zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Executes one arbitrated request at a time against an asynchronous 16-bit
// SRAM with programmable wait states, acknowledging each with a one-cycle
// MEMACK pulse. Out-of-range addresses complete immediately with MEMERR and
// never touch the SRAM.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   MEMREQ/MEMADDR/MEMWRI/MEMDATIN - request (held until MEMACK)
//   MEMACK/MEMERR/memdat          - completion pulse, error flag, read data
//   sram_addr/sram_dq_o/sram_dq_i - SRAM address and data buses
//   sram_dq_oe                    - data bus drive enable
//   sram_ce_n/sram_oe_n/sram_we_n - active-low SRAM strobes
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEMREQ,
  input  logic [31:0]         MEMADDR,
  input  logic                MEMWRI,
  input  logic [MEMDAT_W-1:0] MEMDATIN,
  output logic                MEMACK,
  output logic                MEMERR,
  output logic [MEMDAT_W-1:0] memdat,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [MEMDAT_W-1:0] sram_dq_o,
  input  logic [MEMDAT_W-1:0] sram_dq_i,
  output logic                sram_dq_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  mem_state_e r_state;
  mem_state_e w_next_state;

  logic                r_wri;
  logic                r_ack;
  logic                r_err;
  logic [MEMDAT_W-1:0] r_memdat;
  logic [ADDR_W-1:0]   r_sram_addr;
  logic [MEMDAT_W-1:0] r_sram_dq_o;
  logic                r_dq_oe;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;

  logic w_addr_oor;
  logic w_accept;
  logic w_wri;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_done;
  logic w_capture;
  logic w_ack;
  logic w_err;
  logic w_dq_oe;
  logic w_ce_n;
  logic w_oe_n;
  logic w_we_n;

  assign w_addr_oor = addr_out_of_range(MEMADDR, ADDR_W);

  mem_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  // Next-state logic plus the strobe values the next state will present.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wri        = r_wri;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_capture    = 1'b0;
    w_err        = 1'b0;
    w_ack        = 1'b0;
    w_dq_oe      = 1'b0;
    w_ce_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;

    case (r_state)
      ST_IDLE: begin
        // Direction comes straight from the request while it is being latched.
        w_wri = MEMWRI;
        if (MEMREQ) begin
          w_accept = 1'b1;
          if (w_addr_oor) begin
            w_err        = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_SETUP;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        // Counter holds WAIT_CYCLES during the first ACCESS cycle.
        w_cnt_load   = 1'b1;
        w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_cnt_done) begin
          if (r_wri) begin
            w_next_state = ST_HOLD;
          end else begin
            w_capture    = 1'b1;
            w_next_state = ST_DONE;
          end
        end else begin
          w_cnt_dec    = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_HOLD: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (w_next_state)
      ST_SETUP: begin
        w_ce_n  = 1'b0;
        w_dq_oe = w_wri;
      end
      ST_ACCESS: begin
        // oe_n only drops for reads, so dq_oe and oe_n=0 never coincide.
        w_ce_n  = 1'b0;
        w_dq_oe = w_wri;
        w_oe_n  = w_wri;
        w_we_n  = ~w_wri;
      end
      ST_HOLD: begin
        w_ce_n  = 1'b0;
        w_dq_oe = 1'b1;
      end
      ST_DONE: begin
        w_ack = 1'b1;
      end
      default: begin
        w_ack = 1'b0;
      end
    endcase
  end

  // State register, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wri       <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_memdat    <= 16'h0000;
      r_sram_addr <= '0;
      r_sram_dq_o <= 16'h0000;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_dq_oe <= w_dq_oe;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;

      if (w_accept) begin
        r_wri <= MEMWRI;
      end

      // Out-of-range requests leave the SRAM-facing buses untouched.
      if (w_accept && !w_addr_oor) begin
        r_sram_addr <= MEMADDR[ADDR_W-1:0];
        if (MEMWRI) begin
          r_sram_dq_o <= MEMDATIN;
        end
      end

      if (w_accept && w_addr_oor && !MEMWRI) begin
        r_memdat <= OOR_READ_DATA;
      end else if (w_capture) begin
        r_memdat <= sram_dq_i;
      end
    end
  end

  assign MEMACK     = r_ack;
  assign MEMERR     = r_err;
  assign memdat     = r_memdat;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_sram_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Randomised scoreboard bench for mem_responder with an SRAM device model.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int W  = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEMREQ;
  logic [31:0]   MEMADDR;
  logic          MEMWRI;
  logic [15:0]   MEMDATIN;
  logic          MEMACK;
  logic          MEMERR;
  logic [15:0]   memdat;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o;
  logic [15:0]   sram_dq_i = 16'hDEAD;
  logic          sram_dq_oe;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEMREQ(MEMREQ), .MEMADDR(MEMADDR), .MEMWRI(MEMWRI),
    .MEMDATIN(MEMDATIN), .MEMACK(MEMACK), .MEMERR(MEMERR), .memdat(memdat),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;   // negedge cycle number at which MEMACK must be seen
    logic        err;
    logic        upd;   // memdat takes a new value on this completion
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_ack = -100;
  logic [15:0] exp_memdat = 16'h0000;
  logic        cur_oor = 1'b0;
  int          we_len = 0;
  logic [15:0] we_data = 16'h0000;

  logic [15:0] sram_mem [logic [AW-1:0]];
  logic [15:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [15:0] init_val(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM device model, bus-safety monitor and completion scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 16'hDEAD;

    check("bus_dq_oe_with_oe_n", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
    check("bus_we_n_with_oe_n", 32'(!sram_we_n && !sram_oe_n), 32'd0);
    if (cur_oor)
      check("oor_no_strobe", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);

    if (!sram_we_n) begin
      if (we_len == 0) we_data = sram_dq_o;
      we_len++;
      check("we_low_dq_oe", 32'(sram_dq_oe), 32'd1);
    end else begin
      // Rising we_n with chip still selected is the SRAM write.
      if (we_len != 0 && !sram_ce_n) begin
        check("we_low_len", 32'(we_len), 32'(W + 1));
        check("hold_dq_oe", 32'(sram_dq_oe), 32'd1);
        check("hold_data_stable", 32'(sram_dq_o), 32'(we_data));
        sram_mem[sram_addr] = sram_dq_o;
      end
      we_len = 0;
    end

    if (MEMACK) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_err", 32'(MEMERR), 32'(e.err));
        if (e.upd) exp_memdat = e.data;
        check("memdat", 32'(memdat), 32'(exp_memdat));
      end
    end
  end

  // Issue one request at a negedge and wait for its ack; gap=0 keeps MEMREQ high.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [15:0] d,
                         input int gap);
    exp_t e;
    int   s;
    int   lat;
    int   n;
    logic oor;
    oor      = (a[31:AW] != 14'd0);
    MEMREQ   = 1'b1;
    MEMADDR  = a;
    MEMWRI   = w;
    MEMDATIN = d;
    cur_oor  = oor;
    // Sampling edge: the next edge, but no sooner than two edges after the last ack.
    s   = (cyc + 1 > last_ack + 2) ? cyc + 1 : last_ack + 2;
    lat = oor ? 1 : (w ? W + 4 : W + 3);
    e.cyc  = s + lat - 1;
    e.err  = oor;
    e.upd  = !w;
    e.data = oor ? 16'hFFFF : ref_rd(a[AW-1:0]);
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MEMACK && n < 64);
    if (!MEMACK) begin
      check("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      last_ack = cyc;
      if (w && !oor) ref_mem[a[AW-1:0]] = d;
    end
    if (gap > 0) begin
      MEMREQ = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin : driver
    logic [31:0] a;
    int          r;
    int          n;
    rst = 1'b0; MEMREQ = 1'b0; MEMADDR = 32'h0; MEMWRI = 1'b0; MEMDATIN = 16'h0;
    sram_mem[18'h3FFFF] = 16'h1234;
    ref_mem[18'h3FFFF]  = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_memack", 32'(MEMACK), 32'd0);
    check("rst_memerr", 32'(MEMERR), 32'd0);
    check("rst_memdat", 32'(memdat), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);
    rst = 1'b1;

    // Write then read back.
    run_txn(32'h0000_0123, 1'b1, 16'hBEEF, 1);
    run_txn(32'h0000_0123, 1'b0, 16'h0000, 1);
    // Top of the valid address range.
    run_txn(32'h0003_FFFF, 1'b0, 16'h0000, 1);
    // Out-of-range read and write, then confirm the aliased word is untouched.
    run_txn(32'h0004_0000, 1'b0, 16'h0000, 1);
    run_txn(32'h0004_0000, 1'b1, 16'h5555, 1);
    run_txn(32'h0000_0000, 1'b0, 16'h0000, 1);
    // Back-to-back reads with MEMREQ held high.
    run_txn(32'h0000_0123, 1'b0, 16'h0000, 0);
    run_txn(32'h0003_FFFF, 1'b0, 16'h0000, 0);
    run_txn(32'h0000_0010, 1'b0, 16'h0000, 0);
    run_txn(32'h0000_0011, 1'b0, 16'h0000, 2);

    // Reset during the ACCESS phase of a write.
    cur_oor = 1'b0;
    MEMREQ = 1'b1; MEMADDR = 32'h0000_0200; MEMWRI = 1'b1; MEMDATIN = 16'h7777;
    n = 0;
    while (sram_we_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_access", 32'(sram_we_n), 32'd0);
    rst = 1'b0; MEMREQ = 1'b0;
    @(negedge clk);
    check("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_mid_memack", 32'(MEMACK), 32'd0);
    exp_memdat = 16'h0000;
    last_ack = -100;
    rst = 1'b1;
    run_txn(32'h0000_0200, 1'b0, 16'h0000, 1);

    // Random mix.
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        a = (32'($urandom_range(1, 16383)) << AW) | 32'($urandom_range(0, 262143));
      else if (r == 1)
        a = 32'h0003_FFF0 + 32'($urandom_range(0, 15));
      else
        a = 32'($urandom_range(0, 63));
      run_txn(a, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
              int'($urandom_range(0, 2)));
    end
    MEMREQ = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
